// File: rtl/gray_window_3x3.sv
// gray_window_3x3: 3x3 sliding-window generator for the CNN front end.
// Takes the raster-order gray pixel stream, keeps the two previous lines in
// line buffers and emits every fully populated 3x3 neighbourhood with one
// cycle of latency, plus a pulse when the last pixel of a frame is taken.
// Optional feature macro: GRAY_THRESH_EN (binarize pixels against THRESH
// before they enter the line buffers and the window).
module gray_window_3x3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PX_BW  = 8,
    parameter int THRESH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PX_BW-1:0]     i_px,
    input  logic                 i_in_valid,
    output logic [9*PX_BW-1:0]   o_window,
    output logic                 o_valid,
    output logic                 o_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // One extra bit so a threshold equal to 2**PX_BW means "never set".
    localparam logic [PX_BW:0] THRESH_V = (PX_BW + 1)'(THRESH);

`ifdef GRAY_THRESH_EN
    localparam bit THRESH_ON = 1'b1;
`else
    localparam bit THRESH_ON = 1'b0;
`endif

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PX_BW-1:0] win_q [9];
    logic [PX_BW-1:0] win_d [9];
    logic             valid_q, valid_d;
    logic             frameDone_q, frameDone_d;

    logic [PX_BW-1:0] lb0 [IMG_W];
    logic [PX_BW-1:0] lb1 [IMG_W];

    logic [PX_BW-1:0] pxStore;
    logic [PX_BW-1:0] lb0Rd;
    logic [PX_BW-1:0] lb1Rd;
    logic             accept;
    logic             colLast;
    logic             rowLast;

    assign accept  = i_in_valid;
    assign colLast = (col_q == COL_LAST);
    assign rowLast = (row_q == ROW_LAST);
    assign lb0Rd   = lb0[col_q];
    assign lb1Rd   = lb1[col_q];

    // Value that enters the buffers: raw pixel, or binarized when the threshold option is built in.
    always_comb begin
        pxStore = i_px;
        if (THRESH_ON) begin
            pxStore = ({1'b0, i_px} >= THRESH_V) ? {PX_BW{1'b1}} : {PX_BW{1'b0}};
        end
    end

    // Raster position tracking; wraps straight into the next frame with no idle cycle.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (colLast) begin
                col_d = '0;
                row_d = rowLast ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shifts left by one column and takes {r-2, r-1, r} at the current column on the right.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_d[i] = win_q[i];
        end
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3 + 0] = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb0Rd;
            win_d[5] = lb1Rd;
            win_d[8] = pxStore;
        end
    end

    // A window is complete only once two full lines and two columns of the current line are in.
    always_comb begin
        valid_d     = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
        frameDone_d = accept && colLast && rowLast;
    end

    // Counters, window and output flags; all cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            valid_q     <= 1'b0;
            frameDone_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            valid_q     <= valid_d;
            frameDone_q <= frameDone_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Line buffers move one row older per accepted pixel; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_q] <= lb1Rd;
            lb1[col_q] <= pxStore;
        end
    end

    // Pack the window row-major with the oldest/leftmost pixel in the top byte.
    always_comb begin
        o_window = '0;
        for (int i = 0; i < 9; i++) begin
            o_window[(8 - i)*PX_BW +: PX_BW] = win_q[i];
        end
    end

    assign o_valid      = valid_q;
    assign o_frame_done = frameDone_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Testbench for gray_window_3x3: drives ramp, random, gapped, back-to-back
// and mid-frame-reset pixel streams and compares every output against a
// frame-image reference model kept in the bench.
module tb_gray_window_3x3;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int PX_BW  = 8;
    localparam int THRESH = 128;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [PX_BW-1:0]     i_px;
    logic                 i_in_valid;
    logic [9*PX_BW-1:0]   o_window;
    logic                 o_valid;
    logic                 o_frame_done;

    int checkCount = 0;
    int errorCount = 0;

    logic [PX_BW-1:0] img [IMG_H][IMG_W];
    int mRow;
    int mCol;
    int dutWins;
    int dutDones;
    logic [9*PX_BW-1:0] firstWin;
    logic [9*PX_BW-1:0] lastWin;

    gray_window_3x3 #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PX_BW (PX_BW),
        .THRESH(THRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_px        (i_px),
        .i_in_valid  (i_in_valid),
        .o_window    (o_window),
        .o_valid     (o_valid),
        .o_frame_done(o_frame_done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [9*PX_BW-1:0] observed,
                               input logic [9*PX_BW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h (row %0d col %0d)",
                     tag, observed, expected, mRow, mCol);
        end
    endtask

    // What the design should store for an incoming pixel.
    function automatic logic [PX_BW-1:0] modelStore(input logic [PX_BW-1:0] px);
`ifdef GRAY_THRESH_EN
        return (int'(px) >= THRESH) ? {PX_BW{1'b1}} : {PX_BW{1'b0}};
`else
        return px;
`endif
    endfunction

    // Expected 3x3 neighbourhood ending at (r,c), read straight out of the frame image.
    function automatic logic [9*PX_BW-1:0] modelWindow(input int r, input int c);
        logic [9*PX_BW-1:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                w = {w[8*PX_BW-1:0], img[r - 2 + dr][c - 2 + dc]};
            end
        end
        return w;
    endfunction

    task automatic resetModel();
        mRow     = 0;
        mCol     = 0;
        dutWins  = 0;
        dutDones = 0;
    endtask

    // Optional idle gaps, then one accepted pixel; outputs checked #1 after each edge.
    task automatic applyStimulus(input logic [PX_BW-1:0] px, input int maxGap);
        int   gaps;
        logic expValid;
        logic expDone;
        gaps = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            i_in_valid = 1'b0;
            i_px       = PX_BW'($urandom);
            @(posedge clk);
            #1;
            checkOutput("gap_valid", {71'b0, o_valid}, '0);
            checkOutput("gap_done", {71'b0, o_frame_done}, '0);
        end
        @(negedge clk);
        i_px       = px;
        i_in_valid = 1'b1;
        img[mRow][mCol] = modelStore(px);
        expValid = (mRow >= 2) && (mCol >= 2);
        expDone  = (mRow == IMG_H - 1) && (mCol == IMG_W - 1);
        @(posedge clk);
        #1;
        checkOutput("valid", {71'b0, o_valid}, {71'b0, expValid});
        if (expValid) begin
            checkOutput("window", o_window, modelWindow(mRow, mCol));
        end
        checkOutput("frame_done", {71'b0, o_frame_done}, {71'b0, expDone});
        if (o_valid) begin
            dutWins++;
            if (dutWins == 1) firstWin = o_window;
            lastWin = o_window;
        end
        if (o_frame_done) dutDones++;
        if (mCol == IMG_W - 1) begin
            mCol = 0;
            mRow = (mRow == IMG_H - 1) ? 0 : mRow + 1;
        end else begin
            mCol++;
        end
    endtask

    // One full frame: ramp (index+base) or random pixels, with up to maxGap idle cycles before each.
    task automatic runFrame(input int base, input int maxGap, input bit randomPx);
        for (int idx = 0; idx < NPIX; idx++) begin
            applyStimulus(randomPx ? PX_BW'($urandom) : PX_BW'((idx + base) % 256), maxGap);
        end
    endtask

    task automatic checkFrameCounts(input string tag);
        checkOutput({tag, "_wins"}, 72'(dutWins), 72'(NWIN));
        checkOutput({tag, "_dones"}, 72'(dutDones), 72'd1);
        dutWins  = 0;
        dutDones = 0;
    endtask

    task automatic goIdle();
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        i_in_valid = 1'b0;
        i_px       = '0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_window", o_window, '0);
        checkOutput("rst_valid", {71'b0, o_valid}, '0);
        checkOutput("rst_done", {71'b0, o_frame_done}, '0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] contiguous ramp frame");
        runFrame(0, 0, 1'b0);
        checkFrameCounts("ramp");
`ifndef GRAY_THRESH_EN
        checkOutput("ramp_first_const", firstWin, 72'h0001021C1D1E38393A);
        checkOutput("ramp_last_const", lastWin, 72'hD5D6D7F1F2F30D0E0F);
`endif
        goIdle();

        $display("[TB] ramp frame with random gaps");
        runFrame(0, 3, 1'b0);
        checkFrameCounts("gap_ramp");
        goIdle();

        $display("[TB] back-to-back frames");
        runFrame(0, 0, 1'b0);
        checkFrameCounts("b2b_f1");
        runFrame(100, 0, 1'b0);
        checkFrameCounts("b2b_f2");
`ifndef GRAY_THRESH_EN
        checkOutput("b2b_f2_topleft", {64'b0, firstWin[71:64]}, 72'h64);
`endif
        goIdle();

        $display("[TB] reset after 400 pixels");
        for (int idx = 0; idx < 400; idx++) begin
            applyStimulus(PX_BW'($urandom), 0);
        end
        @(negedge clk);
        i_in_valid = 1'b0;
        reset      = 1'b1;
        #1;
        checkOutput("midrst_window", o_window, '0);
        checkOutput("midrst_valid", {71'b0, o_valid}, '0);
        checkOutput("midrst_done", {71'b0, o_frame_done}, '0);
        @(posedge clk);
        #1;
        checkOutput("midrst_hold_valid", {71'b0, o_valid}, '0);
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        runFrame(0, 0, 1'b0);
        checkFrameCounts("post_rst");
`ifndef GRAY_THRESH_EN
        checkOutput("post_rst_first_const", firstWin, 72'h0001021C1D1E38393A);
`endif
        goIdle();

        $display("[TB] random pixel frame with gaps");
        runFrame(0, 2, 1'b1);
        checkFrameCounts("random");
        goIdle();

        $display("[TB] alternating 127/128 frame");
        for (int idx = 0; idx < NPIX; idx++) begin
            applyStimulus((idx % 2 == 0) ? 8'd127 : 8'd128, 0);
        end
        checkFrameCounts("alt");
        goIdle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Hard time limit so a hung design still produces a verdict.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        errorCount++;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
